gen_io_arb: RTL

GEN_IO_ARB -- requirements
Module: gen_io_arb

---
 rtl/gen_io_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/gen_io_arb.sv
// Two-master arbiter onto a single registered I/O slave bus, with round-robin or
// fixed priority and forced completion when the slave fails to acknowledge in time.
module gen_io_arb #(
    parameter int PRIO_FIXED = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic        MCLK,
    input  logic        RST_N,
    input  logic        m0_req,
    input  logic [4:0]  m0_addr,
    input  logic        m0_wr,
    input  logic [1:0]  m0_be,
    input  logic [15:0] m0_wdata,
    output logic [15:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic [4:0]  m1_addr,
    input  logic        m1_wr,
    input  logic [1:0]  m1_be,
    input  logic [15:0] m1_wdata,
    output logic [15:0] m1_rdata,
    output logic        m1_ack,
    output logic        io_req,
    output logic [4:0]  io_addr,
    output logic        io_wr,
    output logic [1:0]  io_be,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_ack,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      state;
    logic        owner;
    logic        last;
    logic [7:0]  cnt;
    logic        grant1;
    logic [15:0] done_data;

    // last == 1 means master 1 held the previous grant, so master 0 wins a tie.
    always_comb begin
        grant1 = 1'b0;
        if (PRIO_FIXED != 0)
            grant1 = m1_req && !m0_req;
        else
            grant1 = m1_req && (!m0_req || !last);
    end

    always_comb begin
        done_data = 16'hFFFF;
        if (io_ack)
            done_data = io_rdata;
    end

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            io_req      <= 1'b0;
            io_addr     <= '0;
            io_wr       <= 1'b0;
            io_be       <= '0;
            io_wdata    <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner    <= grant1;
                        last     <= grant1;
                        io_req   <= 1'b1;
                        io_addr  <= grant1 ? m1_addr  : m0_addr;
                        io_wr    <= grant1 ? m1_wr    : m0_wr;
                        io_be    <= grant1 ? m1_be    : m0_be;
                        io_wdata <= grant1 ? m1_wdata : m0_wdata;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 8'hFF)
                        cnt <= cnt + 8'd1;
                    // A real ack takes precedence over a timeout in the same cycle.
                    if (io_ack || cnt == TMAX) begin
                        if (owner) begin
                            m1_rdata <= done_data;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= done_data;
                            m0_ack   <= 1'b1;
                        end
                        if (!io_ack)
                            timeout_err <= 1'b1;
                        io_req <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
